// File: rtl/audio_mixer_if.sv
// Bundle of the mixer's sample inputs, mix controls and output word pair.
//
// Handshake: there is no ready/backpressure. fm_valid and psg_valid are
// single-cycle strobes that the producer may assert on any clock; the mixer
// always accepts them (one FM sample may queue while busy, a further one is
// dropped and flagged on ovr). out_valid is a single-cycle pulse on the clock
// where ldata/rdata change; consumers must capture the pair on that cycle.
interface audio_mixer_if #(
  parameter int FM_W  = 14,
  parameter int PSG_W = 10
);
  logic signed [FM_W-1:0] fm_l;
  logic signed [FM_W-1:0] fm_r;
  logic                   fm_valid;
  logic [PSG_W-1:0]       psg;
  logic                   psg_valid;
  logic                   fm_en;
  logic                   psg_en;
  logic                   filt_en;
  logic signed [15:0]     ldata;
  logic signed [15:0]     rdata;
  logic                   out_valid;
  logic                   ovr;
  logic [2:0]             dbg_state;

  modport master (
    output fm_l, fm_r, fm_valid, psg, psg_valid, fm_en, psg_en, filt_en,
    input  ldata, rdata, out_valid, ovr, dbg_state
  );

  modport slave (
    input  fm_l, fm_r, fm_valid, psg, psg_valid, fm_en, psg_en, filt_en,
    output ldata, rdata, out_valid, ovr, dbg_state
  );
endinterface

// File: rtl/audio_mixer.sv
// FM + PSG audio mixer: per-source enables, 16-bit saturation and a one-pole
// low-pass, computed on one shared datapath (left, then right) per FM strobe.
// Output pair commits five clocks after the triggering strobe.
module audio_mixer #(
  parameter int FM_W      = 14,
  parameter int PSG_W     = 10,
  parameter int PSG_SHIFT = 3,
  parameter int FILT_K    = 2
) (
  input  logic          clk,
  input  logic          rst,
  audio_mixer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MIX_L  = 3'd1,
    FILT_L = 3'd2,
    MIX_R  = 3'd3,
    FILT_R = 3'd4,
    COMMIT = 3'd5
  } state_t;

  localparam logic signed [17:0] PSG_MID = 18'sd1 <<< (PSG_W - 1);

  state_t state, state_n;

  // trig: start a new sample this edge; from_buf: take FM from the pending buffer
  logic trig;
  logic from_buf;
  logic fm_busy;

  logic signed [FM_W-1:0] fl, fr;
  logic signed [FM_W-1:0] bl, br;
  logic [PSG_W-1:0]       psg_q, ps;
  logic                   pending;
  logic                   ovr_q;
  logic                   en_fm, en_psg, en_filt;
  logic signed [15:0]     x_q;
  logic signed [15:0]     yl, yr;
  logic signed [15:0]     ldata_q, rdata_q;
  logic                   out_valid_q;

  logic signed [FM_W-1:0] fm_sel;
  logic signed [17:0]     f_ext, p_cent, p_ext, sum;
  logic signed [15:0]     x_sat;
  logic signed [15:0]     y_cur, y_new;
  logic signed [17:0]     diff, y_sum;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and trigger decode; a pending sample wins over a live strobe
  always_comb begin
    state_n  = state;
    trig     = 1'b0;
    from_buf = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          trig     = 1'b1;
          from_buf = 1'b1;
          state_n  = MIX_L;
        end else if (bus.fm_valid) begin
          trig    = 1'b1;
          state_n = MIX_L;
        end
      end
      MIX_L:  state_n = FILT_L;
      FILT_L: state_n = MIX_R;
      MIX_R:  state_n = FILT_R;
      FILT_R: state_n = COMMIT;
      COMMIT: begin
        if (pending) begin
          trig     = 1'b1;
          from_buf = 1'b1;
          state_n  = MIX_L;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A strobe that is not consumed directly as a trigger must queue or overrun
  assign fm_busy = bus.fm_valid && !(trig && !from_buf);

  // PSG capture runs regardless of what the sequencer is doing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                psg_q <= '0;
    else if (bus.psg_valid) psg_q <= bus.psg;
  end

  // Per-sample snapshot of FM, PSG and the mix controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl      <= '0;
      fr      <= '0;
      ps      <= '0;
      en_fm   <= 1'b0;
      en_psg  <= 1'b0;
      en_filt <= 1'b0;
    end else if (trig) begin
      fl      <= from_buf ? bl : bus.fm_l;
      fr      <= from_buf ? br : bus.fm_r;
      ps      <= bus.psg_valid ? bus.psg : psg_q;
      en_fm   <= bus.fm_en;
      en_psg  <= bus.psg_en;
      en_filt <= bus.filt_en;
    end
  end

  // One-deep pending buffer for strobes arriving while busy; overflow is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      bl      <= '0;
      br      <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (trig && from_buf) begin
        pending <= fm_busy;
        if (fm_busy) begin
          bl <= bus.fm_l;
          br <= bus.fm_r;
        end
      end else if (fm_busy) begin
        if (pending) begin
          ovr_q <= 1'b1;
        end else begin
          pending <= 1'b1;
          bl      <= bus.fm_l;
          br      <= bus.fm_r;
        end
      end
    end
  end

  // Shared mix path: FM left-aligned to 16 bits plus centred, scaled PSG
  always_comb begin
    fm_sel = (state == MIX_L) ? fl : fr;
    f_ext  = en_fm ? (18'(fm_sel) <<< (16 - FM_W)) : 18'sd0;
    p_cent = $signed({{(18 - PSG_W){1'b0}}, ps}) - PSG_MID;
    p_ext  = en_psg ? (p_cent <<< PSG_SHIFT) : 18'sd0;
    sum    = f_ext + p_ext;
    if (sum > 18'sd32767)       x_sat = 16'sh7fff;
    else if (sum < -18'sd32768) x_sat = 16'sh8000;
    else                        x_sat = sum[15:0];
  end

  // Shared filter path; with the filter off the state still follows x
  always_comb begin
    y_cur = (state == FILT_L) ? yl : yr;
    diff  = 18'(x_q) - 18'(y_cur);
    y_sum = 18'(y_cur) + (diff >>> FILT_K);
    y_new = en_filt ? y_sum[15:0] : x_q;
  end

  // Datapath registers advanced by the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      yl  <= '0;
      yr  <= '0;
    end else begin
      case (state)
        MIX_L, MIX_R: x_q <= x_sat;
        FILT_L:       yl  <= y_new;
        FILT_R:       yr  <= y_new;
        default:      ;
      endcase
    end
  end

  // Both channels commit on the same edge so the pair is never torn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldata_q     <= '0;
      rdata_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state == COMMIT);
      if (state == COMMIT) begin
        ldata_q <= yl;
        rdata_q <= yr;
      end
    end
  end

  assign bus.ldata     = ldata_q;
  assign bus.rdata     = rdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovr       = ovr_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: directed scenarios plus randomized strobes, all
// checked against an arithmetic model of the mix and filter.
module tb_audio_mixer;

  localparam int W = 64;  // {out cycle, ldata, rdata}

  logic clk;
  logic rst;
  audio_mixer_if bus ();

  audio_mixer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  logic [W-1:0] exp_q[$];

  // Model state
  int ym_l = 0;
  int ym_r = 0;
  logic [9:0] m_psg_q;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst)                m_psg_q <= '0;
    else if (bus.psg_valid) m_psg_q <= bus.psg;
  end

  function automatic int mix(input int fm, input int p, input bit fe, input bit pe);
    int v;
    v = (fe ? fm * 4 : 0) + (pe ? (p - 512) * 8 : 0);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic int filt(input int y, input int x, input bit fe);
    return fe ? y + ((x - y) >>> 2) : x;
  endfunction

  // Scoreboard: every out_valid pulse must match the next expected pair and cycle
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      logic [W-1:0] e;
      pulse_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid cyc=%0d ldata=%0d rdata=%0d", cyc, bus.ldata, bus.rdata);
      end else begin
        e = exp_q.pop_front();
        if (e[63:32] !== 32'(cyc) || bus.ldata !== e[31:16] || bus.rdata !== e[15:0]) begin
          n_err++;
          $display("FAIL out_pair cyc=%0d l=%0d r=%0d expected cyc=%0d l=%0d r=%0d",
                   cyc, bus.ldata, bus.rdata, e[63:32], $signed(e[31:16]), $signed(e[15:0]));
        end
      end
    end
  end

  // Driver: one clock of stimulus; push records the model's expected output
  task automatic step(input bit fv, input logic [13:0] l, input logic [13:0] r,
                      input bit pv, input logic [9:0] p, input bit push, input int lat);
    int fi, ri, pi, xl, xr;
    bus.fm_valid  = fv;
    bus.fm_l      = l;
    bus.fm_r      = r;
    bus.psg_valid = pv;
    bus.psg       = p;
    if (push) begin
      fi = $signed(l);
      ri = $signed(r);
      pi = pv ? int'(p) : int'(m_psg_q);
      xl = mix(fi, pi, bus.fm_en, bus.psg_en);
      xr = mix(ri, pi, bus.fm_en, bus.psg_en);
      ym_l = filt(ym_l, xl, bus.filt_en);
      ym_r = filt(ym_r, xr, bus.filt_en);
      exp_q.push_back({32'(cyc + 1 + lat), 16'(ym_l), 16'(ym_r)});
    end
    @(posedge clk);
    #1;
    bus.fm_valid  = 1'b0;
    bus.psg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bus.fm_l, bus.fm_r, 1'b0, bus.psg, 1'b0, 0);
  endtask

  task automatic rand_idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, bus.fm_l, bus.fm_r, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ym_l = 0;
    ym_r = 0;
    exp_q.delete();
    #1;
  endtask

  task automatic set_en(input bit fe, input bit pe, input bit fl);
    bus.fm_en   = fe;
    bus.psg_en  = pe;
    bus.filt_en = fl;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.ldata !== 16'd0 || bus.rdata !== 16'd0 || bus.out_valid !== 1'b0 ||
        bus.ovr !== 1'b0 || bus.dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state l=%h r=%h ov=%b ovr=%b st=%0d expected all zero",
               bus.ldata, bus.rdata, bus.out_valid, bus.ovr, bus.dbg_state);
    end
  endtask

  task automatic test_fm_only();
    int p0;
    set_en(1, 0, 0);
    p0 = pulse_cnt;
    step(1'b1, 14'h1000, 14'h3000, 1'b0, 10'd0, 1'b1, 5);
    idle(8);
    n_cmp++;
    if (bus.ldata !== 16'h4000 || bus.rdata !== 16'hC000 || pulse_cnt - p0 != 1) begin
      n_err++;
      $display("FAIL fm_only l=%h r=%h pulses=%0d expected 4000 C000 1",
               bus.ldata, bus.rdata, pulse_cnt - p0);
    end
  endtask

  task automatic test_saturation();
    set_en(1, 1, 0);
    step(1'b1, 14'h1FFF, 14'h2000, 1'b1, 10'd1023, 1'b1, 5);
    idle(7);
    n_cmp++;
    if (bus.ldata !== 16'sd32767) begin
      n_err++;
      $display("FAIL sat_pos ldata=%0d expected 32767", bus.ldata);
    end
    step(1'b1, 14'h1FFF, 14'h2000, 1'b1, 10'd0, 1'b1, 5);
    idle(7);
    n_cmp++;
    if (bus.rdata !== 16'sh8000) begin
      n_err++;
      $display("FAIL sat_neg rdata=%0d expected -32768", bus.rdata);
    end
  endtask

  task automatic test_filter();
    logic [15:0] want [3];
    want[0] = 16'd1024;
    want[1] = 16'd1792;
    want[2] = 16'd2368;
    do_reset();
    set_en(1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 14'h0400, 14'h0000, 1'b0, 10'd0, 1'b1, 5);
      idle(9);
      n_cmp++;
      if (bus.ldata !== want[i] || bus.rdata !== 16'd0) begin
        n_err++;
        $display("FAIL filter_step%0d l=%0d r=%0d expected %0d 0", i, bus.ldata, bus.rdata, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    set_en(1, 0, 0);
    p0 = pulse_cnt;
    step(1'b1, 14'h0100, 14'h0200, 1'b0, 10'd0, 1'b1, 5);
    idle(1);
    step(1'b1, 14'h0300, 14'h3F00, 1'b0, 10'd0, 1'b1, 8);
    idle(12);
    n_cmp++;
    if (bus.ovr !== 1'b0 || pulse_cnt - p0 != 2 || bus.ldata !== 16'h0C00 || bus.rdata !== 16'hFC00) begin
      n_err++;
      $display("FAIL b2b_pair ovr=%b pulses=%0d l=%h r=%h expected 0 2 0C00 FC00",
               bus.ovr, pulse_cnt - p0, bus.ldata, bus.rdata);
    end
    p0 = pulse_cnt;
    step(1'b1, 14'h0010, 14'h0020, 1'b0, 10'd0, 1'b1, 5);
    idle(1);
    step(1'b1, 14'h0030, 14'h0040, 1'b0, 10'd0, 1'b1, 8);
    step(1'b1, 14'h0050, 14'h0060, 1'b0, 10'd0, 1'b0, 0);
    idle(12);
    n_cmp++;
    if (bus.ovr !== 1'b1 || pulse_cnt - p0 != 2) begin
      n_err++;
      $display("FAIL b2b_drop ovr=%b pulses=%0d expected 1 2", bus.ovr, pulse_cnt - p0);
    end
  endtask

  task automatic test_psg_timing();
    set_en(1, 1, 0);
    step(1'b1, 14'h0000, 14'h0000, 1'b1, 10'd768, 1'b1, 5);
    idle(1);
    step(1'b0, 14'h0000, 14'h0000, 1'b1, 10'd900, 1'b0, 0);
    idle(6);
    n_cmp++;
    if (bus.ldata !== 16'd2048 || bus.rdata !== 16'd2048) begin
      n_err++;
      $display("FAIL psg_snapshot l=%0d r=%0d expected 2048 2048", bus.ldata, bus.rdata);
    end
    step(1'b1, 14'h0000, 14'h0000, 1'b0, 10'd0, 1'b1, 5);
    idle(7);
    n_cmp++;
    if (bus.ldata !== 16'd3104 || bus.rdata !== 16'd3104) begin
      n_err++;
      $display("FAIL psg_next l=%0d r=%0d expected 3104 3104", bus.ldata, bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    set_en(1, 0, 1);
    step(1'b1, 14'h0800, 14'h3800, 1'b0, 10'd0, 1'b0, 0);
    idle(2);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ldata !== 16'd0 || bus.rdata !== 16'd0 || bus.out_valid !== 1'b0 || bus.ovr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid l=%h r=%h ov=%b ovr=%b expected 0", bus.ldata, bus.rdata, bus.out_valid, bus.ovr);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ym_l = 0;
    ym_r = 0;
    exp_q.delete();
    p0 = pulse_cnt;
    step(1'b1, 14'h0800, 14'h3800, 1'b0, 10'd0, 1'b1, 5);
    idle(7);
    n_cmp++;
    if (bus.ldata !== 16'd2048 || bus.rdata !== 16'hF800 || pulse_cnt - p0 != 1) begin
      n_err++;
      $display("FAIL reset_restart l=%h r=%h pulses=%0d expected 0800 F800 1",
               bus.ldata, bus.rdata, pulse_cnt - p0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      set_en(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'b1, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'b1, 5);
      rand_idle($urandom_range(5, 9));
    end
    idle(8);
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b0;
    bus.fm_l = '0;
    bus.fm_r = '0;
    bus.fm_valid = 1'b0;
    bus.psg = '0;
    bus.psg_valid = 1'b0;
    set_en(0, 0, 0);
    #2;
    test_reset();
    test_fm_only();
    test_saturation();
    test_filter();
    test_psg_timing();
    test_random();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_outputs left=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Upstream stage of the board audio output path.
- Combines the FM synthesizer stereo samples with the mono PSG sample, applies per-source enables, saturation and an optional one-pole low-pass filter.
- Delivers the 16-bit signed ldata/rdata words that the audio shifter/codec interface serialises.
- Runs one time-multiplexed datapath: left channel, then right channel, once per FM sample strobe.

Parameters:
- FM_W, 14, width of signed FM samples; left-aligned to 16 bits by shifting left (16-FM_W).
- PSG_W, 10, width of the unsigned PSG sample.
- PSG_SHIFT, 3, left shift applied to the centred PSG sample.
- FILT_K, 2, IIR coefficient shift; y += (x-y)>>>FILT_K.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- fm_l  in  FM_W  signed FM left sample.
- fm_r  in  FM_W  signed FM right sample.
- fm_valid  in  1  single-cycle strobe; new FM sample pair; triggers one output sample.
- psg  in  PSG_W  unsigned PSG sample.
- psg_valid  in  1  single-cycle strobe; new PSG sample.
- fm_en  in  1  include FM in the mix.
- psg_en  in  1  include PSG in the mix.
- filt_en  in  1  enable low-pass; 0 = pass-through.
- ldata  out  16  signed left output sample.
- rdata  out  16  signed right output sample.
- out_valid  out  1  single-cycle pulse when ldata/rdata update.
- ovr  out  1  sticky overrun flag.

Behaviour:
- Reset (async, rst=1): the following are cleared to 0:
  - ldata, rdata, out_valid, ovr
  - filter states yl, yr
  - PSG capture register, pending flag
  - FSM enters IDLE.
- PSG capture: psg latched into psg_q on every clock with psg_valid=1, independent of FSM state.
- Trigger: in IDLE, fm_valid=1 at edge N causes the following at that edge:
  - snapshot fm_l/fm_r into fl/fr;
  - snapshot PSG into ps; if psg_valid is also high at edge N, the new psg value is used, otherwise psg_q;
  - FSM goes to MIX_L.
- FSM sequence: IDLE -> MIX_L -> FILT_L -> MIX_R -> FILT_R -> COMMIT -> IDLE, or -> trigger again if pending. One state per cycle.
- Latency: ldata/rdata update and out_valid=1 at edge N+5. out_valid is low on all other cycles.
- Mix, per channel (18-bit signed arithmetic):
  - f = fm_en ? sext(fm) << (16-FM_W) : 0
  - p = psg_en ? (ps - 2^(PSG_W-1)) << PSG_SHIFT : 0
  - x = sat16(f + p), clamped to [-32768, 32767].
- Filter:
  - filt_en=1: y = y + ((x - y) >>> FILT_K). Arithmetic shift, 18-bit intermediate; the result always stays within 16-bit range.
  - filt_en=0: y = x. The filter state tracks x so that re-enabling causes no step.
  - filt_en is sampled at the trigger edge and held for the whole sample.
- COMMIT: ldata = yl and rdata = yr, written in the same edge. The outputs never show a half-updated pair.
- Busy handling, fm_valid while FSM is not IDLE:
  - pending clear: set pending. After COMMIT, the FSM retriggers immediately from COMMIT using the fm_l/fm_r values captured at the pending edge, held in a second buffer, and clears pending.
  - pending already set: the sample is dropped and ovr is set (sticky until reset).
  - fm_valid in the COMMIT cycle is treated as pending.
- psg_valid during processing updates psg_q only; the in-flight snapshot is unaffected.
- Enable changes mid-sample take effect from the next trigger.

Test Plan:
- Reset, then FM only: fm_en=1, psg_en=0, filt_en=0; fm_l=0x1000, fm_r=0x3000 (-4096), fm_valid at edge N -> at edge N+5 ldata=0x4000, rdata=0xC000 (-16384), out_valid=1 for exactly one cycle.
- Positive saturation: fm_l=8191, psg=1023, both enables on -> 32764+4088 clamps to ldata=32767. Negative saturation: fm_r=-8192, psg=0 -> rdata=-32768.
- Filter step response: filt_en=1, fm_l=0x0400, psg_en=0, three fm_valid strobes 10 cycles apart -> ldata sequence 1024, 1792, 2368.
- Back-to-back triggers: fm_valid at N and N+2 -> out_valid at N+5 and N+10 with the respective samples, ovr=0. A third strobe at N+3 -> dropped, ovr=1, still only two out_valid pulses.
- PSG timing: psg_valid with psg=768 coincident with fm_valid (fm=0, fm_en=1, psg_en=1) -> ldata=rdata=2048. psg_valid=900 at N+2 does not alter that output; it is used on the next trigger.
- Async reset asserted at N+3 mid-sample -> all outputs 0 immediately, no out_valid. After release, the next fm_valid produces an output 5 cycles later with filter state starting from 0.
